// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package data_memory_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned WORD_ADDR_WIDTH = WORD_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    // Latched request; the byte offset bits are dropped since accesses are word-aligned.
    typedef struct packed {
        logic                       write;
        logic [WORD_ADDR_WIDTH-1:0] word_address;
        logic [WORD_WIDTH-1:0]      write_data;
        logic [BYTE_LANES-1:0]      byte_enable;
    } mem_req_t;

    function automatic logic [WORD_WIDTH-1:0] expand_byte_mask(input logic [BYTE_LANES-1:0] be);
        logic [WORD_WIDTH-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < BYTE_LANES; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word-organised storage with per-byte-lane write enables and a registered read port.
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    input  logic [BYTE_LANES-1:0]    i_byte_we,
    input  logic [WORD_WIDTH-1:0]    i_wdata,
    output logic [WORD_WIDTH-1:0]    o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

    // Contents are intentionally not reset; read returns the pre-write value on a collision.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BYTE_LANES; i++) begin
            if (i_byte_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data memory responder: one outstanding load/store, programmable wait states,
// valid/ready on both the request and response sides.
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned WAIT_CYCLES   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  requestValid,
    output logic                  requestReady,
    input  logic                  requestWrite,
    input  logic [WORD_WIDTH-1:0] requestAddress,
    input  logic [WORD_WIDTH-1:0] requestWriteData,
    input  logic [BYTE_LANES-1:0] requestByteEnable,
    output logic                  responseValid,
    input  logic                  responseReady,
    output logic [WORD_WIDTH-1:0] responseData,
    output logic                  responseError,
    output logic                  busy
);

    localparam int unsigned CNT_W = 4;

    state_e                   r_state;
    state_e                   w_next_state;
    logic [CNT_W-1:0]         r_wait_cnt;
    mem_req_t                 r_req;
    logic                     r_resp_valid;
    logic [WORD_WIDTH-1:0]    r_resp_data;
    logic                     r_resp_error;

    logic                     w_accept;
    logic                     w_resp_done;
    logic                     w_addr_error;
    logic [ADDRESS_WIDTH-1:0] w_array_addr;
    logic [BYTE_LANES-1:0]    w_array_we;
    logic [WORD_WIDTH-1:0]    w_array_rdata;
    logic                     w_unused_byte_offset;

    assign w_unused_byte_offset = ^requestAddress[1:0];

    assign w_accept     = requestValid && (r_state == ST_IDLE);
    assign w_resp_done  = r_resp_valid && responseReady;
    assign w_addr_error = (r_req.word_address[WORD_ADDR_WIDTH-1:ADDRESS_WIDTH] != '0)
                       || (r_req.byte_enable == '0);

    // Read address tracks the incoming request while idle so a zero-wait load sees its word at ACCESS.
    assign w_array_addr = (r_state == ST_IDLE) ? requestAddress[ADDRESS_WIDTH+1:2]
                                               : r_req.word_address[ADDRESS_WIDTH-1:0];
    assign w_array_we   = (r_state == ST_ACCESS && r_req.write && !w_addr_error)
                        ? r_req.byte_enable : '0;

    data_memory_array #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_array (
        .clk      (clock),
        .i_addr   (w_array_addr),
        .i_byte_we(w_array_we),
        .i_wdata  (r_req.write_data),
        .o_rdata  (w_array_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next_state = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (w_resp_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch, wait counter and response register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt   <= '0;
            r_req        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req.write        <= requestWrite;
                        r_req.word_address <= requestAddress[WORD_WIDTH-1:2];
                        r_req.write_data   <= requestWriteData;
                        r_req.byte_enable  <= requestByteEnable;
                        r_wait_cnt         <= (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= w_addr_error;
                    r_resp_data  <= (w_addr_error || r_req.write)
                                  ? '0
                                  : (w_array_rdata & expand_byte_mask(r_req.byte_enable));
                end
                ST_RESPOND: begin
                    if (w_resp_done) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign requestReady  = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign responseValid = r_resp_valid;
    assign responseData  = r_resp_data;
    assign responseError = r_resp_error;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 and 0 wait states) checked against a
// transaction-level model every cycle, plus directed literal expectations.
module tb_data_memory_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rv   [2];
    logic        rw   [2];
    logic [31:0] ra   [2];
    logic [31:0] rwd  [2];
    logic [3:0]  rbe  [2];
    logic        rr   [2];
    logic        rdy  [2];
    logic        rsp_v[2];
    logic [31:0] rsp_d[2];
    logic        rsp_e[2];
    logic        bsy  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_memory_responder #(
            .ADDRESS_WIDTH(10),
            .WAIT_CYCLES  ((g == 0) ? 2 : 0)
        ) u_dut (
            .clock            (clock),
            .reset            (reset),
            .requestValid     (rv[g]),
            .requestReady     (rdy[g]),
            .requestWrite     (rw[g]),
            .requestAddress   (ra[g]),
            .requestWriteData (rwd[g]),
            .requestByteEnable(rbe[g]),
            .responseValid    (rsp_v[g]),
            .responseReady    (rr[g]),
            .responseData     (rsp_d[g]),
            .responseError    (rsp_e[g]),
            .busy             (bsy[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: cycles since acceptance, memory as a plain array.
    bit          m_busy [2];
    int          m_cnt  [2];
    bit          m_wr   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_be   [2];
    logic [31:0] m_data [2];
    bit          m_err  [2];
    bit          m_known[2];
    logic [31:0] mmem   [2][1024];
    bit          mvalid [2][1024];

    function automatic int wait_of(input int g);
        return (g == 0) ? 2 : 0;
    endfunction

    task automatic model_access(input int g);
        int          idx;
        logic [31:0] word;
        idx = int'(m_addr[g][11:2]);
        if (m_addr[g] >= 32'h1000 || m_be[g] == 4'h0) begin
            m_data[g] = 32'h0; m_err[g] = 1'b1; m_known[g] = 1'b1;
        end else if (m_wr[g]) begin
            word = mmem[g][idx];
            for (int b = 0; b < 4; b++)
                if (m_be[g][b]) word[8*b +: 8] = m_wdata[g][8*b +: 8];
            mmem[g][idx] = word;
            if (m_be[g] == 4'hF) mvalid[g][idx] = 1'b1;
            m_data[g] = 32'h0; m_err[g] = 1'b0; m_known[g] = 1'b1;
        end else begin
            word = 32'h0;
            for (int b = 0; b < 4; b++)
                if (m_be[g][b]) word[8*b +: 8] = mmem[g][idx][8*b +: 8];
            m_data[g] = word; m_err[g] = 1'b0; m_known[g] = mvalid[g][idx];
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int g = 0; g < 2; g++) begin
                m_busy[g] = 1'b0;
                m_cnt[g]  = 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (!m_busy[g]) begin
                    if (rv[g] === 1'b1) begin
                        m_busy[g] = 1'b1; m_cnt[g] = 0;
                        m_wr[g] = rw[g]; m_addr[g] = ra[g]; m_wdata[g] = rwd[g]; m_be[g] = rbe[g];
                    end
                end else if (m_cnt[g] == wait_of(g) + 1) begin
                    if (rr[g] === 1'b1) m_busy[g] = 1'b0;
                end else begin
                    m_cnt[g]++;
                    if (m_cnt[g] == wait_of(g) + 1) model_access(g);
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            bit exp_v;
            exp_v = m_busy[g] && (m_cnt[g] == wait_of(g) + 1);
            check($sformatf("u%0d_requestReady", g), 32'(rdy[g]), 32'(!m_busy[g]));
            check($sformatf("u%0d_busy", g), 32'(bsy[g]), 32'(m_busy[g]));
            check($sformatf("u%0d_responseValid", g), 32'(rsp_v[g]), 32'(exp_v));
            if (exp_v && m_known[g]) begin
                check($sformatf("u%0d_responseData", g), rsp_d[g], m_data[g]);
                check($sformatf("u%0d_responseError", g), 32'(rsp_e[g]), 32'(m_err[g]));
            end
        end
    end

    task automatic transact(input int g, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be, input int hold,
                            output logic [31:0] rdata, output logic rerr, output int lat);
        int guard;
        guard = 0;
        while (rdy[g] !== 1'b1 && guard < 50) begin
            @(negedge clock); guard++;
        end
        check("ready_timeout", 32'(guard >= 50), 32'h0);
        rv[g] = 1'b1; rw[g] = wr; ra[g] = addr; rwd[g] = data; rbe[g] = be;
        @(posedge clock);
        @(negedge clock);
        rv[g] = 1'b0; ra[g] = 32'hFFFF_FFFC; rwd[g] = ~data; rbe[g] = 4'h0;
        lat = 0;
        while (rsp_v[g] !== 1'b1 && lat < 50) begin
            @(posedge clock); lat++;
            @(negedge clock);
        end
        check("response_timeout", 32'(lat >= 50), 32'h0);
        rdata = rsp_d[g];
        rerr  = rsp_e[g];
        for (int k = 0; k < hold; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("bp_valid_held", 32'(rsp_v[g]), 32'h1);
            check("bp_data_stable", rsp_d[g], rdata);
            check("bp_error_stable", 32'(rsp_e[g]), 32'(rerr));
            check("bp_ready_low", 32'(rdy[g]), 32'h0);
        end
        rr[g] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rr[g] = 1'b0;
        check("idle_after_handshake", 32'(rdy[g]), 32'h1);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        for (int g = 0; g < 2; g++) begin
            rv[g] = 1'b0; rw[g] = 1'b0; ra[g] = '0; rwd[g] = '0; rbe[g] = '0; rr[g] = 1'b0;
        end
        repeat (2) @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            check("rst_requestReady", 32'(rdy[g]), 32'h1);
            check("rst_responseValid", 32'(rsp_v[g]), 32'h0);
            check("rst_responseData", rsp_d[g], 32'h0);
            check("rst_responseError", 32'(rsp_e[g]), 32'h0);
            check("rst_busy", 32'(bsy[g]), 32'h0);
        end
        reset = 1'b1;
        @(negedge clock);

        // Store then load, two wait states.
        transact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, d, e, lat);
        check("st_latency", 32'(lat), 32'd3);
        check("st_data", d, 32'h0);
        check("st_error", 32'(e), 32'h0);
        transact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, d, e, lat);
        check("ld_latency", 32'(lat), 32'd3);
        check("ld_data", d, 32'hDEADBEEF);

        // Partial store and partial load.
        transact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, d, e, lat);
        transact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, d, e, lat);
        transact(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, d, e, lat);
        check("partial_store", d, 32'h11BB33DD);
        transact(0, 1'b0, 32'h20, 32'h0, 4'hC, 0, d, e, lat);
        check("partial_load", d, 32'h11BB0000);

        // Error rejection.
        transact(0, 1'b1, 32'h0, 32'h00000055, 4'hF, 0, d, e, lat);
        transact(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, d, e, lat);
        check("oob_error", 32'(e), 32'h1);
        check("oob_data", d, 32'h0);
        transact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, d, e, lat);
        check("be0_error", 32'(e), 32'h1);
        check("be0_data", d, 32'h0);
        transact(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, d, e, lat);
        check("after_error_data", d, 32'h00000055);
        check("after_error_error", 32'(e), 32'h0);

        // Zero wait states with backpressure.
        transact(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, d, e, lat);
        check("w0_st_latency", 32'(lat), 32'd1);
        transact(1, 1'b0, 32'h40, 32'h0, 4'hF, 5, d, e, lat);
        check("w0_ld_latency", 32'(lat), 32'd1);
        check("w0_ld_data", d, 32'hCAFEF00D);

        // Reset while a store is waiting.
        transact(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 0, d, e, lat);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h30; rwd[0] = 32'h12345678; rbe[0] = 4'hF;
        @(posedge clock);
        @(negedge clock);
        rv[0] = 1'b0;
        check("pre_reset_busy", 32'(bsy[0]), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_requestReady", 32'(rdy[0]), 32'h1);
        check("mid_rst_responseValid", 32'(rsp_v[0]), 32'h0);
        check("mid_rst_responseData", rsp_d[0], 32'h0);
        check("mid_rst_responseError", 32'(rsp_e[0]), 32'h0);
        check("mid_rst_busy", 32'(bsy[0]), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        transact(0, 1'b0, 32'h30, 32'h0, 4'hF, 0, d, e, lat);
        check("reset_store_dropped", d, 32'h0BADF00D);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the CPU's MEM-stage data accesses. Accepts one load or store request at a time over a valid/ready handshake and models a configurable number of wait states. Performs the access against an internal word array and returns data or a write acknowledge over a second valid/ready handshake. Drives `busy`, which the pipeline uses to stall MEM and everything upstream of it.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 10: word-address bits; array holds 2^ADDRESS_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2: wait states inserted per access, range 0..15.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `requestValid`  in  1  request present.
- `requestReady`  out  1  responder can accept a request.
- `requestWrite`  in  1  1 = store, 0 = load.
- `requestAddress`  in  32  byte address; bits [1:0] ignored.
- `requestWriteData`  in  32  store data.
- `requestByteEnable`  in  4  bit i selects byte lane [8i+7:8i].
- `responseValid`  out  1  response present.
- `responseReady`  in  1  consumer takes the response.
- `responseData`  out  32  load data with disabled lanes forced to 0. It is 0 for stores and for errors.
- `responseError`  out  1  request was rejected (see Operation).
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- State machine: IDLE, WAIT, ACCESS, RESPOND.
- IDLE
  - `requestReady`=1.
  - When `requestValid`&`requestReady` are high at an edge, latch all request fields.
  - If WAIT_CYCLES=0, go to ACCESS; otherwise go to WAIT with the counter set to WAIT_CYCLES-1.
- WAIT
  - If the counter is 0, go to ACCESS; otherwise decrement the counter.
  - Request inputs are ignored.
- ACCESS
  - Error check: the latched request is an error if `requestAddress[31:ADDRESS_WIDTH+2]`≠0 or `requestByteEnable`=0.
  - Error case: no array access. The edge loads `responseData`=0 and `responseError`=1.
  - Store: the enabled lanes of word `requestAddress[ADDRESS_WIDTH+1:2]` are written at the edge. `responseData`=0 and `responseError`=0.
  - Load: the edge registers the array word masked by the byte enables, with `responseError`=0.
  - Next state is RESPOND.
- RESPOND
  - `responseValid`=1 and held, along with data and error, until `responseValid`&`responseReady` are high at an edge; then go to IDLE.
  - `requestReady`=0 throughout RESPOND. A new request cannot be accepted on the same edge as the response handshake.
- The array is not reset; its contents are undefined until written.
- `requestReady`=(state==IDLE) and `busy`=!requestReady; both are decoded directly from the state register.

## Timing
- Reset values: state IDLE, `requestReady`=1, `responseValid`=0, `responseData`=0, `responseError`=0, `busy`=0, counter 0.
- Latency: with the request accepted at edge E0, `responseValid` rises after edge E0+WAIT_CYCLES+1.
- Worked latency, WAIT_CYCLES=2: accept at E0; states WAIT, WAIT, ACCESS; RESPOND after E3.
- Minimum request-to-request spacing is WAIT_CYCLES+3 cycles, reached when `responseReady` is held high.
- Store commit: occurs at the ACCESS edge. A load issued after the store's response sees the new data.
- Reset asserted mid-operation:
  - Return to IDLE immediately.
  - A store is not committed if reset arrives before its ACCESS edge.
  - A pending response is discarded.
- Backpressure: `responseReady` low in RESPOND holds all outputs stable indefinitely.
- `requestValid` deasserted in IDLE: no state change.

## Structure
- Shared package `data_memory_pkg`:
  - state enum (IDLE, WAIT, ACCESS, RESPOND);
  - `WORD_WIDTH`=32;
  - `BYTE_LANES`=4;
  - a byte-mask expansion function (4 bits to 32 bits).
- Sub-module `data_memory_array`: 2^ADDRESS_WIDTH×32 storage with a per-lane write enable and a synchronous read, instantiated once.
- Top level: FSM, wait counter, request latch, error check, response register.

## Test plan
- Store then load, WAIT_CYCLES=2:
  - Stimulus: store 0xDEADBEEF to address 0x10 with BE=0xF, then load 0x10 with BE=0xF.
  - Required: `responseData`=0xDEADBEEF; each `responseValid` rises exactly 3 edges after acceptance; `busy` is high across both transactions.
- Partial store:
  - Stimulus: write 0x11223344 to address 0x20 with BE=0xF, then write 0xAABBCCDD with BE=0x5, then load with BE=0xF.
  - Required: load returns 0x11BB33DD.
- Partial load:
  - Stimulus: after the partial-store scenario, load address 0x20 with BE=0xC.
  - Required: `responseData`=0x11BB0000.
- Error rejection, ADDRESS_WIDTH=10:
  - Stimulus: store to address 0x1000, or any request with BE=0.
  - Required: `responseError`=1 and `responseData`=0; a later load from 0x0 still returns its previous contents.
- Backpressure and zero wait states, WAIT_CYCLES=0:
  - Stimulus: hold `responseReady`=0 for 5 cycles.
  - Required: `responseValid` rises 1 edge after acceptance and stays high with data stable; `requestReady` stays 0; IDLE is reached on the edge where `responseReady` is 1.
- Reset mid-store:
  - Stimulus: store 0x12345678 to address 0x30 during WAIT, then assert `reset` low.
  - Required: all outputs take their reset values immediately; a later load from 0x30 returns the value written before that store.
